// File: rtl/uart_cmd_parser.sv
// ASCII-hex command parser: buffers UART bytes in a small FIFO and turns
// "w<addr> <d>..." / "r<addr> <len>" lines into write/read requests.
module uart_cmd_parser #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  output logic              err,
  output logic              ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, LEN, ISSUE_WR, ISSUE_RD, SKIP
  } state_t;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wptr_reg, rptr_reg;
  logic              fifo_full, fifo_empty, push, drop, pop;
  logic [7:0]        head, lc;
  logic              is_digit, is_af, is_hex, is_space, is_eol;
  logic [3:0]        nibble;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic              is_wr_reg, is_wr_next;
  logic              has_digit_reg, has_digit_next;
  logic              eol_reg, eol_next;
  logic              wr_valid_reg, wr_valid_next;
  logic              rd_valid_reg, rd_valid_next;
  logic              err_reg, err_next;
  logic              ovf_reg, abort_reg;
  logic              fault;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wptr_reg == rptr_reg);
  assign fifo_full  = (wptr_reg[PTR_W] != rptr_reg[PTR_W]) &&
                      (wptr_reg[PTR_W-1:0] == rptr_reg[PTR_W-1:0]);
  assign push = rx_valid && !fifo_full;
  assign drop = rx_valid && fifo_full;
  assign head = fifo_mem[rptr_reg[PTR_W-1:0]];

  // Folding bit 5 makes letters case-insensitive; only letter compares use lc.
  assign lc       = head | 8'h20;
  assign is_digit = (head >= 8'h30) && (head <= 8'h39);
  assign is_af    = (lc >= 8'h61) && (lc <= 8'h66);
  assign is_hex   = is_digit || is_af;
  assign is_space = (head == 8'h20);
  assign is_eol   = (head == 8'h0D) || (head == 8'h0A);
  assign nibble   = is_digit ? head[3:0] : head[3:0] + 4'd9;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_reg[PTR_W-1:0]] <= rx_data;
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    len_next       = len_reg;
    is_wr_next     = is_wr_reg;
    has_digit_next = has_digit_reg;
    eol_next       = eol_reg;
    wr_valid_next  = wr_valid_reg;
    rd_valid_next  = rd_valid_reg;
    err_next       = 1'b0;
    fault          = 1'b0;
    pop            = 1'b0;
    case (state_reg)
      ISSUE_WR: if (wr_ready) begin
        wr_valid_next  = 1'b0;
        addr_next      = addr_reg + ADDR_W'(1);
        data_next      = '0;
        has_digit_next = 1'b0;
        state_next     = eol_reg ? IDLE : DATA;
      end
      ISSUE_RD: if (rd_ready) begin
        rd_valid_next = 1'b0;
        state_next    = IDLE;
      end
      default: if (!fifo_empty) begin
        pop = 1'b1;
        if (abort_reg) begin
          // A dropped byte corrupted the current command; SKIP already reported it.
          err_next   = (state_reg != SKIP);
          state_next = is_eol ? IDLE : SKIP;
        end else begin
          case (state_reg)
            IDLE: begin
              if (lc == 8'h77 || lc == 8'h72) begin
                state_next     = ADDR;
                is_wr_next     = (lc == 8'h77);
                addr_next      = '0;
                data_next      = '0;
                len_next       = '0;
                has_digit_next = 1'b0;
              end else if (!is_space && !is_eol) begin
                fault = 1'b1;
              end
            end
            ADDR: begin
              if (is_hex) begin
                addr_next      = {addr_reg[ADDR_W-5:0], nibble};
                has_digit_next = 1'b1;
              end else if (is_space) begin
                if (has_digit_reg) begin
                  has_digit_next = 1'b0;
                  state_next     = is_wr_reg ? DATA : LEN;
                end
              end else if (is_eol) begin
                err_next   = 1'b1;
                state_next = IDLE;
              end else begin
                fault = 1'b1;
              end
            end
            DATA: begin
              if (is_hex) begin
                data_next      = {data_reg[DATA_W-5:0], nibble};
                has_digit_next = 1'b1;
              end else if (is_space || is_eol) begin
                if (has_digit_reg) begin
                  wr_valid_next = 1'b1;
                  eol_next      = is_eol;
                  state_next    = ISSUE_WR;
                end else if (is_eol) begin
                  state_next = IDLE;
                end
              end else begin
                fault = 1'b1;
              end
            end
            LEN: begin
              if (is_hex) begin
                len_next       = {len_reg[LEN_W-5:0], nibble};
                has_digit_next = 1'b1;
              end else if (is_eol) begin
                if (has_digit_reg && len_reg != '0) begin
                  rd_valid_next = 1'b1;
                  state_next    = ISSUE_RD;
                end else begin
                  err_next   = 1'b1;
                  state_next = IDLE;
                end
              end else begin
                fault = 1'b1;
              end
            end
            SKIP: if (is_eol) state_next = IDLE;
            default: state_next = IDLE;
          endcase
        end
      end
    endcase
    if (fault) begin
      err_next   = 1'b1;
      state_next = SKIP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      data_reg      <= '0;
      len_reg       <= '0;
      is_wr_reg     <= 1'b0;
      has_digit_reg <= 1'b0;
      eol_reg       <= 1'b0;
      wr_valid_reg  <= 1'b0;
      rd_valid_reg  <= 1'b0;
      err_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      abort_reg     <= 1'b0;
      wptr_reg      <= '0;
      rptr_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      len_reg       <= len_next;
      is_wr_reg     <= is_wr_next;
      has_digit_reg <= has_digit_next;
      eol_reg       <= eol_next;
      wr_valid_reg  <= wr_valid_next;
      rd_valid_reg  <= rd_valid_next;
      err_reg       <= err_next;
      if (push) wptr_reg <= wptr_reg + (PTR_W+1)'(1);
      if (pop)  rptr_reg <= rptr_reg + (PTR_W+1)'(1);
      if (drop) begin
        ovf_reg   <= 1'b1;
        abort_reg <= 1'b1;
      end else if (pop) begin
        abort_reg <= 1'b0;
      end
    end
  end

  assign wr_valid = wr_valid_reg;
  assign wr_addr  = addr_reg;
  assign wr_data  = data_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_addr  = addr_reg;
  assign rd_len   = len_reg;
  assign err      = err_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed scenarios plus randomized commands whose
// expected requests are derived from the command text when it is generated.
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wr_valid, wr_ready, rd_valid, rd_ready, err, ovf;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [7:0]  rd_len;

  int checks = 0;
  int failures = 0;

  logic wr_fix = 1'b0, rd_fix = 1'b0, rand_mode = 1'b0;

  logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$];
  logic [7:0]  exp_rl[$];
  int          exp_err;
  logic [31:0] got_wa[$], got_wd[$], got_ra[$];
  logic [7:0]  got_rl[$];
  int          got_err = 0;

  logic        hold_ok = 1'b0, prev_wv, prev_wr, prev_rv, prev_rr;
  logic [31:0] prev_wa, prev_wd, prev_ra;
  logic [7:0]  prev_rl;

  uart_cmd_parser dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_len(rd_len),
    .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    wr_ready = rand_mode ? 1'($urandom_range(0, 1)) : wr_fix;
    rd_ready = rand_mode ? 1'($urandom_range(0, 1)) : rd_fix;
  end

  // Observe handshakes and hold behaviour mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (wr_valid && wr_ready) begin got_wa.push_back(wr_addr); got_wd.push_back(wr_data); end
      if (rd_valid && rd_ready) begin got_ra.push_back(rd_addr); got_rl.push_back(rd_len); end
      if (err) got_err++;
      if (wr_valid && rd_valid) check("both_valid", 64'(wr_valid & rd_valid), 64'd0);
      if (rd_valid) check("rd_len_nz", 64'(rd_len != 8'd0), 64'd1);
      if (hold_ok && prev_wv && !prev_wr) begin
        check("wr_hold_v", 64'(wr_valid), 64'd1);
        check("wr_hold_a", 64'(wr_addr), 64'(prev_wa));
        check("wr_hold_d", 64'(wr_data), 64'(prev_wd));
      end
      if (hold_ok && prev_rv && !prev_rr) begin
        check("rd_hold_v", 64'(rd_valid), 64'd1);
        check("rd_hold_a", 64'(rd_addr), 64'(prev_ra));
        check("rd_hold_l", 64'(rd_len), 64'(prev_rl));
      end
      prev_wv = wr_valid; prev_wr = wr_ready; prev_wa = wr_addr; prev_wd = wr_data;
      prev_rv = rd_valid; prev_rr = rd_ready; prev_ra = rd_addr; prev_rl = rd_len;
      hold_ok = 1'b1;
    end else begin
      hold_ok = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic clear_all();
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); exp_rl.delete(); exp_err = 0;
    got_wa.delete(); got_wd.delete(); got_ra.delete(); got_rl.delete(); got_err = 0;
  endtask

  task automatic settle(input string tag);
    int t = 0;
    while ((got_wa.size() < exp_wa.size() || got_ra.size() < exp_ra.size()) && t < 600) begin
      tick(1);
      t++;
    end
    check({tag, "_timeout"}, 64'(t < 600), 64'd1);
    tick(24);
    check({tag, "_wcnt"}, 64'(got_wa.size()), 64'(exp_wa.size()));
    check({tag, "_rcnt"}, 64'(got_ra.size()), 64'(exp_ra.size()));
    for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
      check($sformatf("%s_wa%0d", tag, i), 64'(got_wa[i]), 64'(exp_wa[i]));
      check($sformatf("%s_wd%0d", tag, i), 64'(got_wd[i]), 64'(exp_wd[i]));
    end
    for (int i = 0; i < exp_ra.size() && i < got_ra.size(); i++) begin
      check($sformatf("%s_ra%0d", tag, i), 64'(got_ra[i]), 64'(exp_ra[i]));
      check($sformatf("%s_rl%0d", tag, i), 64'(got_rl[i]), 64'(exp_rl[i]));
    end
    check({tag, "_err"}, 64'(got_err), 64'(exp_err));
    $display("txn %s writes=%0d reads=%0d errs=%0d", tag, got_wa.size(), got_ra.size(), got_err);
    clear_all();
  endtask

  function automatic string eol();
    string e;
    if ($urandom_range(0, 1) == 1) e = "\n";
    else e = $sformatf("%c", 8'd13);
    return e;
  endfunction

  // Random hex digits, mixed case; value keeps only the low w bits.
  task automatic gen_hex(input int n, input int w, output string s, output logic [63:0] v);
    string hs;
    int    d;
    byte   c;
    hs = "0123456789abcdef";
    s = "";
    v = 0;
    for (int i = 0; i < n; i++) begin
      d = $urandom_range(0, 15);
      c = hs[d];
      if (d >= 10 && $urandom_range(0, 1) == 1) c = c - 8'd32;
      s = $sformatf("%s%c", s, c);
      v = ((v << 4) | 64'(d)) & ((64'd1 << w) - 64'd1);
    end
  endtask

  task automatic gen_cmd(input int kind, output string s);
    string       as, ds, ls, bad;
    logic [63:0] av, dv, lv;
    logic [31:0] wa[$], wd[$];
    int          nd;
    case (kind)
      0: begin
        do begin
          wa.delete(); wd.delete();
          gen_hex($urandom_range(1, 10), 32, as, av);
          s = ($urandom_range(0, 1) == 1) ? "w" : "W";
          s = {s, as};
          nd = $urandom_range(1, 3);
          for (int i = 0; i < nd; i++) begin
            gen_hex($urandom_range(1, 9), 32, ds, dv);
            s = {s, " ", ds};
            wa.push_back(av[31:0] + 32'(i));
            wd.push_back(dv[31:0]);
          end
          if ($urandom_range(0, 3) == 0) s = {s, " "};
          s = {s, eol()};
        end while (s.len() > 16);
        foreach (wa[i]) begin exp_wa.push_back(wa[i]); exp_wd.push_back(wd[i]); end
      end
      1: begin
        gen_hex($urandom_range(1, 10), 32, as, av);
        do gen_hex($urandom_range(1, 2), 8, ls, lv); while (lv == 0);
        s = ($urandom_range(0, 1) == 1) ? "r" : "R";
        s = {s, as, " ", ls, eol()};
        exp_ra.push_back(av[31:0]);
        exp_rl.push_back(lv[7:0]);
      end
      2: begin
        gen_hex($urandom_range(1, 6), 32, as, av);
        s = {"r", as, " 0", eol()};
        exp_err = 1;
      end
      3: begin
        bad = "xqz!+";
        gen_hex($urandom_range(0, 5), 32, as, av);
        s = {$sformatf("%c", bad[$urandom_range(0, 4)]), as, eol()};
        exp_err = 1;
      end
      4: begin
        gen_hex($urandom_range(1, 4), 32, as, av);
        gen_hex($urandom_range(1, 3), 32, ds, dv);
        s = {"w", as, " ", ds, " g1", eol()};
        exp_wa.push_back(av[31:0]);
        exp_wd.push_back(dv[31:0]);
        exp_err = 1;
      end
      default: begin
        gen_hex($urandom_range(1, 6), 32, as, av);
        s = {"W", as, " ", eol()};
      end
    endcase
  endtask

  task automatic wait_wr_valid(input string tag);
    int t = 0;
    while (!wr_valid && t < 100) begin tick(1); t++; end
    check(tag, 64'(wr_valid), 64'd1);
  endtask

  initial begin
    string s;
    int    kind;
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    wr_ready = 1'b0; rd_ready = 1'b0;
    clear_all();
    tick(3);
    check("rst_wr_valid", 64'(wr_valid), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_rd_len", 64'(rd_len), 64'd0);
    rstn = 1'b1;
    tick(2);

    wr_fix = 1'b1; rd_fix = 1'b1;
    send_str("w10 DEADBEEF 12\n");
    exp_wa = '{32'h10, 32'h11}; exp_wd = '{32'hDEADBEEF, 32'h12};
    settle("t1");

    rd_fix = 1'b0;
    send_str({"R0000FF00 20", eol()});
    tick(50);
    check("t2_held_v", 64'(rd_valid), 64'd1);
    check("t2_held_a", 64'(rd_addr), 64'hFF00);
    check("t2_held_l", 64'(rd_len), 64'h20);
    check("t2_no_hs", 64'(got_ra.size()), 64'd0);
    rd_fix = 1'b1;
    exp_ra = '{32'hFF00}; exp_rl = '{8'h20};
    settle("t2");

    send_str("x12\nr4 3\n");
    exp_ra = '{32'h4}; exp_rl = '{8'h3}; exp_err = 1;
    settle("t3");

    send_str("r4 0\n");
    exp_err = 1;
    settle("t4a");
    send_str("w123456789 1\n");
    exp_wa = '{32'h23456789}; exp_wd = '{32'h1};
    settle("t4b");

    wr_fix = 1'b0;
    send_str("w3 4\n");
    wait_wr_valid("t5_pend");
    s = "w5 6 7 8 9 a b c d e";
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (i == 15) check("t5_ovf_b16", 64'(ovf), 64'd0);
      if (i == 16) check("t5_ovf_b17", 64'(ovf), 64'd1);
    end
    wr_fix = 1'b1;
    tick(40);
    send_str("\n");
    send_str("w1 5\n");
    exp_wa = '{32'h3, 32'h1}; exp_wd = '{32'h4, 32'h5}; exp_err = 1;
    settle("t5");

    wr_fix = 1'b0;
    send_str("w9 1\n");
    wait_wr_valid("t6_pend");
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    check("t6_wr_valid", 64'(wr_valid), 64'd0);
    check("t6_wr_addr", 64'(wr_addr), 64'd0);
    check("t6_wr_data", 64'(wr_data), 64'd0);
    check("t6_rd_valid", 64'(rd_valid), 64'd0);
    check("t6_ovf", 64'(ovf), 64'd0);
    clear_all();
    wr_fix = 1'b1;
    send_str("w2 7\n");
    exp_wa = '{32'h2}; exp_wd = '{32'h7};
    settle("t6");

    rand_mode = 1'b1;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      gen_cmd(kind, s);
      send_str(s);
      settle($sformatf("rnd%0d_k%0d", n, kind));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
